// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data-memory bus, resolves branch/jump
// redirects and holds the MEM/WB pipeline register. All state moves on the falling edge.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_in,
    input  logic [1:0]  MemtoReg_in,
    input  logic        Branch_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Jump_in,
    input  logic [31:0] jump_addr_in,
    input  logic [31:0] branch_addr_in,
    input  logic [31:0] PC_plus_4_in,
    input  logic        ALU_zero_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] reg_read_data_2_in,
    input  logic [4:0]  EX_MEM_RegisterRd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic [1:0]  pc_src,
    output logic [31:0] pc_target,
    output logic        flush_out,
    output logic        mem_error,
    output logic        RegWrite_wb,
    output logic [1:0]  MemtoReg_wb,
    output logic [31:0] ALU_result_wb,
    output logic [31:0] mem_data_wb,
    output logic [31:0] PC_plus_4_wb,
    output logic [4:0]  MEM_WB_RegisterRd_out,
    output logic [31:0] wb_write_data
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic [7:0]  wait_cnt_reg;
    logic [31:0] rdata_buf_reg;
    logic        acc_err_reg;   // timeout happened on the access currently retiring
    logic        acc;

    assign acc       = MemRead_in | MemWrite_in;
    assign mem_stall = ((state_reg == IDLE) && acc) || (state_reg == BUSY);

    always_ff @(negedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            rdata_buf_reg <= '0;
            acc_err_reg   <= 1'b0;
            mem_error     <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (acc) begin
                        mem_req      <= 1'b1;
                        mem_we       <= MemWrite_in;
                        mem_addr     <= ALU_result_in;
                        mem_wdata    <= reg_read_data_2_in;
                        wait_cnt_reg <= '0;
                        acc_err_reg  <= 1'b0;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req       <= 1'b0;
                        // Writes (including read+write) return no data
                        rdata_buf_reg <= mem_we ? 32'h0 : mem_rdata;
                        state_reg     <= DONE;
                    end else if (wait_cnt_reg == LAST_WAIT) begin
                        mem_req       <= 1'b0;
                        mem_error     <= 1'b1;
                        acc_err_reg   <= 1'b1;
                        rdata_buf_reg <= '0;
                        state_reg     <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise retire the EX/MEM instruction
    always_ff @(negedge clk) begin
        if (rst) begin
            RegWrite_wb           <= 1'b0;
            MemtoReg_wb           <= 2'b00;
            ALU_result_wb         <= '0;
            mem_data_wb           <= '0;
            PC_plus_4_wb          <= '0;
            MEM_WB_RegisterRd_out <= '0;
        end else if (mem_stall) begin
            RegWrite_wb <= 1'b0;
            MemtoReg_wb <= 2'b00;
        end else begin
            RegWrite_wb           <= RegWrite_in & ~((state_reg == DONE) & acc_err_reg);
            MemtoReg_wb           <= MemtoReg_in;
            ALU_result_wb         <= ALU_result_in;
            PC_plus_4_wb          <= PC_plus_4_in;
            MEM_WB_RegisterRd_out <= EX_MEM_RegisterRd_in;
            mem_data_wb           <= (state_reg == DONE) ? rdata_buf_reg : 32'h0;
        end
    end

    always_comb begin
        pc_src    = 2'b00;
        pc_target = 32'h0;
        if (!mem_stall) begin
            if (Jump_in) begin
                pc_src    = 2'b10;
                pc_target = jump_addr_in;
            end else if (Branch_in && ALU_zero_in) begin
                pc_src    = 2'b01;
                pc_target = branch_addr_in;
            end else begin
                pc_src    = 2'b00;
                pc_target = PC_plus_4_in;
            end
        end
    end

    assign flush_out = (pc_src != 2'b00);

    always_comb begin
        wb_write_data = ALU_result_wb;
        case (MemtoReg_wb)
            2'b01:   wb_write_data = mem_data_wb;
            2'b10:   wb_write_data = PC_plus_4_wb;
            default: wb_write_data = ALU_result_wb;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stimulus pushes expected write-back
// entries into a queue; a monitor pops one per MEM/WB capture and compares.
module tb_mem_access_stage;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_in, Branch_in, MemRead_in, MemWrite_in, Jump_in, ALU_zero_in;
    logic [1:0]  MemtoReg_in;
    logic [31:0] jump_addr_in, branch_addr_in, PC_plus_4_in, ALU_result_in, reg_read_data_2_in;
    logic [4:0]  EX_MEM_RegisterRd_in;
    logic        mem_req, mem_we, mem_ack, mem_stall, flush_out, mem_error, RegWrite_wb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_target;
    logic [1:0]  pc_src, MemtoReg_wb;
    logic [31:0] ALU_result_wb, mem_data_wb, PC_plus_4_wb, wb_write_data;
    logic [4:0]  MEM_WB_RegisterRd_out;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Jump_in(Jump_in),
        .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in), .PC_plus_4_in(PC_plus_4_in),
        .ALU_zero_in(ALU_zero_in), .ALU_result_in(ALU_result_in),
        .reg_read_data_2_in(reg_read_data_2_in), .EX_MEM_RegisterRd_in(EX_MEM_RegisterRd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .pc_src(pc_src), .pc_target(pc_target), .flush_out(flush_out), .mem_error(mem_error),
        .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb), .ALU_result_wb(ALU_result_wb),
        .mem_data_wb(mem_data_wb), .PC_plus_4_wb(PC_plus_4_wb),
        .MEM_WB_RegisterRd_out(MEM_WB_RegisterRd_out), .wb_write_data(wb_write_data)
    );

    typedef struct {
        logic        rw;
        logic [1:0]  mtr;
        logic        mr, mw, br, jp, zero;
        logic [31:0] alu, sdata, baddr, jaddr, pc4;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        int          id;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wb;
        logic [31:0] md;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    function automatic instr_t mk(input logic rw, input logic [1:0] mtr, input logic mr, input logic mw,
                                  input logic br, input logic jp, input logic zero,
                                  input logic [31:0] alu, input logic [31:0] sdata,
                                  input logic [31:0] baddr, input logic [31:0] jaddr,
                                  input logic [31:0] pc4, input logic [4:0] rd);
        instr_t i;
        i.rw = rw; i.mtr = mtr; i.mr = mr; i.mw = mw; i.br = br; i.jp = jp; i.zero = zero;
        i.alu = alu; i.sdata = sdata; i.baddr = baddr; i.jaddr = jaddr; i.pc4 = pc4; i.rd = rd;
        return i;
    endfunction

    function automatic exp_t mkexp(input int id, input logic rw, input logic [4:0] rd,
                                   input logic [31:0] wb, input logic [31:0] md);
        exp_t e;
        e.id = id; e.rw = rw; e.rd = rd; e.wb = wb; e.md = md;
        return e;
    endfunction

    task automatic drive(input instr_t i);
        RegWrite_in = i.rw; MemtoReg_in = i.mtr; MemRead_in = i.mr; MemWrite_in = i.mw;
        Branch_in = i.br; Jump_in = i.jp; ALU_zero_in = i.zero; ALU_result_in = i.alu;
        reg_read_data_2_in = i.sdata; branch_addr_in = i.baddr; jump_addr_in = i.jaddr;
        PC_plus_4_in = i.pc4; EX_MEM_RegisterRd_in = i.rd;
    endtask

    // Called right after a rising edge; returns on the rising edge after retirement.
    task automatic issue(input instr_t i, input exp_t e, input int ack_after, input logic [31:0] rdata,
                         input int exp_stalls, input int exp_busy,
                         input logic [1:0] exp_src, input logic [31:0] exp_tgt);
        int   stalls = 0;
        int   busy = 0;
        bit   seen_req = 1'b0;
        bit   done = 1'b0;
        logic st;
        drive(i);
        sb_q.push_back(e);
        for (int c = 0; c < 64 && !done; c++) begin
            if (mem_req) begin
                busy++;
                if (!seen_req) begin
                    seen_req = 1'b1;
                    check("mem_addr", mem_addr, i.alu);
                    check("mem_we", {31'b0, mem_we}, {31'b0, i.mw});
                    if (i.mw) check("mem_wdata", mem_wdata, i.sdata);
                end
                if (ack_after >= 0 && busy == ack_after + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
            end
            #3;
            st = mem_stall;
            if (st) stalls++;
            else begin
                check("pc_src", {30'b0, pc_src}, {30'b0, exp_src});
                check("pc_target", pc_target, exp_tgt);
                check("flush_out", {31'b0, flush_out}, {31'b0, (exp_src != 2'b00)});
            end
            @(negedge clk);
            #1;
            if (st) check("bubble_regwrite", {31'b0, RegWrite_wb}, 32'h0);
            @(posedge clk);
            mem_ack = 1'b0;
            mem_rdata = 32'h0;
            if (!st) done = 1'b1;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL retire_timeout: instruction %0d never retired", e.id);
        end
        check("req_seen", {31'b0, seen_req}, {31'b0, (i.mr | i.mw)});
        check("stall_cycles", stalls, exp_stalls);
        check("busy_cycles", busy, exp_busy);
    endtask

    // Monitor: one comparison set per MEM/WB capture (a falling edge with no stall)
    initial begin
        logic st, r, en;
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            st = mem_stall; r = rst; en = mon_en;
            @(negedge clk);
            #1;
            if (en && !r && !st) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_wb: rd=%0d wb=%h with empty queue", MEM_WB_RegisterRd_out, wb_write_data);
                end else begin
                    e = sb_q.pop_front();
                    $display("txn %0d: rw=%0b rd=%0d wb=%h md=%h", e.id, RegWrite_wb,
                             MEM_WB_RegisterRd_out, wb_write_data, mem_data_wb);
                    check("RegWrite_wb", {31'b0, RegWrite_wb}, {31'b0, e.rw});
                    check("rd_wb", {27'b0, MEM_WB_RegisterRd_out}, {27'b0, e.rd});
                    check("wb_write_data", wb_write_data, e.wb);
                    check("mem_data_wb", mem_data_wb, e.md);
                end
            end
        end
    end

    instr_t nop, ld;
    int busy_cnt;

    initial begin
        nop = mk(0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        drive(nop);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_stall", {31'b0, mem_stall}, 32'h0);
        check("rst_regwrite", {31'b0, RegWrite_wb}, 32'h0);
        check("rst_wb_data", wb_write_data, 32'h0);
        check("rst_mem_error", {31'b0, mem_error}, 32'h0);
        @(posedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // ALU op, no access
        issue(mk(1, 2'b00, 0, 0, 0, 0, 0, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h4, 5'd5),
              mkexp(1, 1, 5'd5, 32'h1234, 32'h0), -1, 32'h0, 0, 0, 2'b00, 32'h4);
        // Load 0x40, ack in the 4th BUSY cycle
        issue(mk(1, 2'b01, 1, 0, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, 32'h8, 5'd7),
              mkexp(2, 1, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF), 3, 32'hDEADBEEF, 5, 4, 2'b00, 32'h8);
        // Store with immediate ack; bus data must not be captured
        issue(mk(0, 2'b00, 0, 1, 0, 0, 0, 32'h80, 32'hA5A5A5A5, 32'h0, 32'h0, 32'hC, 5'd0),
              mkexp(3, 0, 5'd0, 32'h80, 32'h0), 0, 32'h11111111, 2, 1, 2'b00, 32'hC);
        // Taken branch
        issue(mk(0, 2'b00, 0, 0, 1, 0, 1, 32'h0, 32'h0, 32'h100, 32'h0, 32'h54, 5'd0),
              mkexp(4, 0, 5'd0, 32'h0, 32'h0), -1, 32'h0, 0, 0, 2'b01, 32'h100);
        // Jump beats branch; link value PC+4 written back
        issue(mk(1, 2'b10, 0, 0, 1, 1, 1, 32'h0, 32'h0, 32'h100, 32'h200, 32'h58, 5'd31),
              mkexp(5, 1, 5'd31, 32'h58, 32'h0), -1, 32'h0, 0, 0, 2'b10, 32'h200);
        // Untaken branch
        issue(mk(0, 2'b00, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h5C, 5'd0),
              mkexp(6, 0, 5'd0, 32'h0, 32'h0), -1, 32'h0, 0, 0, 2'b00, 32'h5C);
        // Load that times out: no write-back, error raised
        issue(mk(1, 2'b01, 1, 0, 0, 0, 0, 32'h90, 32'h0, 32'h0, 32'h0, 32'h60, 5'd9),
              mkexp(7, 0, 5'd9, 32'h0, 32'h0), -1, 32'h0, 5, TIMEOUT, 2'b00, 32'h60);
        check("mem_error_set", {31'b0, mem_error}, 32'h1);
        // Following ALU op writes back normally, MemtoReg=11 selects ALU
        issue(mk(1, 2'b11, 0, 0, 0, 0, 0, 32'hCAFE, 32'h0, 32'h0, 32'h0, 32'h64, 5'd10),
              mkexp(8, 1, 5'd10, 32'hCAFE, 32'h0), -1, 32'h0, 0, 0, 2'b00, 32'h64);
        check("mem_error_sticky", {31'b0, mem_error}, 32'h1);
        // Read+write together behaves as a write: no data returned
        issue(mk(1, 2'b01, 1, 1, 0, 0, 0, 32'hA0, 32'h13572468, 32'h0, 32'h0, 32'h68, 5'd3),
              mkexp(9, 1, 5'd3, 32'h0, 32'h0), 1, 32'h77777777, 3, 2, 2'b00, 32'h68);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        check("queue_drained", sb_q.size(), 0);

        // Reset in the 2nd BUSY cycle of a load, then a late ack
        mon_en = 1'b0;
        ld = mk(1, 2'b01, 1, 0, 0, 0, 0, 32'hB0, 32'h0, 32'h0, 32'h0, 32'h70, 5'd4);
        drive(ld);
        busy_cnt = 0;
        for (int c = 0; c < 20 && busy_cnt < 2; c++) begin
            @(posedge clk);
            if (mem_req) busy_cnt++;
        end
        check("reset_test_busy", busy_cnt, 2);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        drive(nop);
        mem_ack = 1'b1;
        mem_rdata = 32'hFEEDF00D;
        #3;
        check("mid_rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("mid_rst_mem_stall", {31'b0, mem_stall}, 32'h0);
        check("mid_rst_mem_error", {31'b0, mem_error}, 32'h0);
        check("mid_rst_regwrite", {31'b0, RegWrite_wb}, 32'h0);
        check("mid_rst_wb_data", wb_write_data, 32'h0);
        @(negedge clk);
        #1;
        check("late_ack_mem_req", {31'b0, mem_req}, 32'h0);
        check("late_ack_mem_data", mem_data_wb, 32'h0);
        check("late_ack_mem_stall", {31'b0, mem_stall}, 32'h0);
        @(posedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        mon_en = 1'b1;

        // Normal operation after reset
        issue(mk(1, 2'b00, 0, 0, 0, 0, 0, 32'h55, 32'h0, 32'h0, 32'h0, 32'h74, 5'd6),
              mkexp(10, 1, 5'd6, 32'h55, 32'h0), -1, 32'h0, 0, 0, 2'b00, 32'h74);
        check("final_queue", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage: consumes the EX/MEM pipeline register outputs, drives a multi-cycle data-memory bus (req/ack handshake), resolves branch/jump redirects, and contains the MEM/WB pipeline register.
- Stalls the front of the pipeline while a load/store is outstanding.
- Produces write-back data for the register file.

Parameters:
- TIMEOUT, 16, max cycles waiting for mem_ack before the access is aborted with an error (range 1..255).

Ports:
- clk  in  1  clock; all state updates on falling edge, same as adjacent pipeline registers
- rst  in  1  reset, synchronous, active-high
- RegWrite_in  in  1  from EX/MEM
- MemtoReg_in  in  2  from EX/MEM; 00 ALU, 01 mem, 10 PC+4, 11 ALU
- Branch_in, MemRead_in, MemWrite_in, Jump_in  in  1 each  from EX/MEM
- jump_addr_in, branch_addr_in, PC_plus_4_in  in  32 each  from EX/MEM
- ALU_zero_in  in  1  from EX/MEM
- ALU_result_in, reg_read_data_2_in  in  32 each  from EX/MEM; address / store data
- EX_MEM_RegisterRd_in  in  5  from EX/MEM
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write, registered
- mem_addr, mem_wdata  out  32 each  registered
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  32  valid when mem_ack=1
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- pc_src  out  2  00 PC+4, 01 branch, 10 jump
- pc_target  out  32  redirect address
- flush_out  out  1  flush younger stages
- mem_error  out  1  sticky timeout flag
- RegWrite_wb  out  1  MEM/WB register
- MemtoReg_wb  out  2  MEM/WB register
- ALU_result_wb, mem_data_wb, PC_plus_4_wb  out  32 each  MEM/WB register
- MEM_WB_RegisterRd_out  out  5  MEM/WB register
- wb_write_data  out  32  combinational mux of the MEM/WB fields by MemtoReg_wb

Behaviour:
- Access is defined as acc = MemRead_in | MemWrite_in.
  - Both MemRead_in and MemWrite_in set: treated as a write; no read data returned (mem_data_wb = 0).
- FSM states: IDLE, BUSY, DONE.
  - IDLE, acc=1: next edge registers mem_req=1, mem_we=MemWrite_in, mem_addr=ALU_result_in, mem_wdata=reg_read_data_2_in; clear wait counter; go to BUSY.
  - BUSY, mem_ack=1: drop mem_req; latch mem_rdata into an internal buffer (reads only); go to DONE.
  - BUSY, counter reaches TIMEOUT-1 without ack: drop mem_req; set mem_error; buffer = 0; go to DONE.
  - DONE: go to IDLE unconditionally; the access is retired this cycle.
  - mem_ack while not BUSY is ignored.
- mem_stall (combinational) = (IDLE & acc) | BUSY.
  - Deasserted in DONE, so EX/MEM advances on the DONE edge.
  - A back-to-back access therefore costs a minimum of 3 cycles: IDLE, BUSY with ack, DONE.
- Redirect (combinational, forced to 0 while mem_stall=1):
  - Jump_in: pc_src=10, pc_target=jump_addr_in.
  - else Branch_in & ALU_zero_in: pc_src=01, pc_target=branch_addr_in.
  - else pc_src=00, pc_target=PC_plus_4_in.
  - Jump beats branch.
  - flush_out = (pc_src != 00).
- MEM/WB register, each falling edge:
  - mem_stall=1: insert bubble (RegWrite_wb=0, MemtoReg_wb=00); data fields hold.
  - State DONE: capture the *_in fields; mem_data_wb = buffer. If mem_error was set by this access, RegWrite_wb=0 (no write of garbage).
  - IDLE, no access: capture the *_in fields; mem_data_wb = 0.
- wb_write_data selects ALU_result_wb, mem_data_wb, or PC_plus_4_wb by MemtoReg_wb; 11 selects ALU_result_wb.
- Reset (rst=1 at an edge), overrides everything including a mid-access:
  - All outputs 0, state IDLE, counter 0, mem_error cleared, mem_req dropped immediately.
  - A late mem_ack after reset is ignored.
- mem_error is sticky until rst.

Test Plan:
- ALU op (RegWrite=1, MemtoReg=00, ALU_result=0x1234, Rd=5), no access -> next edge RegWrite_wb=1, wb_write_data=0x1234, MEM_WB_RegisterRd_out=5, mem_stall never 1.
- Load addr 0x40, ack after 3 BUSY cycles with rdata 0xDEADBEEF:
  - mem_req=1, mem_addr=0x40, mem_we=0; mem_stall=1 for 5 cycles.
  - RegWrite_wb=0 during the stall, then 1 with wb_write_data=0xDEADBEEF.
- Store data 0xA5A5A5A5 to 0x80, immediate ack -> mem_we=1, mem_wdata=0xA5A5A5A5; stall 2 cycles; mem_data_wb=0.
- Branch=1, zero=1, branch_addr=0x100 -> pc_src=01, pc_target=0x100, flush_out=1.
  - Same with Jump=1, jump_addr=0x200 -> pc_src=10, pc_target=0x200.
  - zero=0, no jump -> pc_src=00, flush_out=0.
- TIMEOUT=4, load with no ack -> mem_req drops after 4 BUSY cycles; mem_error=1 and stays 1; RegWrite_wb=0 for that load; the next ALU op writes back normally.
- rst asserted in the 2nd BUSY cycle, ack pulsed the following cycle -> all outputs 0, state IDLE, mem_stall=0, ack ignored, mem_error=0.
